vector_load_writeback: RTL

- Downstream stage of the vector load/store unit. Consumes the element stream that unit drives on its vector bus during a vector load.
- Writes elements 0..VL-1 into one selected vector register of a banked vector register file.
- Provides one registered read port for the vector functional units.
- Reports completion, element count and overrun status to the vector controller.

---
 rtl/vector_load_writeback.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vector_load_writeback.sv
// Vector load writeback: writes elements 0..VL-1 of a load stream into one vector register. Optional macro: VLW_WRITE_BYPASS_EN.
// Write latency 1 cycle, registered read port 1 cycle; there is no backpressure, so beats outside an armed operation are dropped and flagged as overrun.
module vector_load_writeback #(
  parameter int NUM_VREGS = 8,
  parameter int MAX_VL    = 64,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_enable,
  input  logic [$clog2(NUM_VREGS)-1:0] vreg_sel,
  input  logic [31:0]                  VLR,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  input  logic [$clog2(NUM_VREGS)-1:0] rd_sel,
  input  logic [$clog2(MAX_VL)-1:0]    rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         busy,
  output logic                         wb_done,
  output logic [$clog2(MAX_VL):0]      elem_count,
  output logic                         overrun
);

  localparam int VSW = $clog2(NUM_VREGS);
  localparam int IW  = $clog2(MAX_VL);
  localparam int CW  = IW + 1;
  localparam int AW  = VSW + IW;

  typedef enum logic [1:0] {IDLE, ARMED, FILL, DONE} state_t;

  state_t           state_q, state_d;
  logic [VSW-1:0]   vsel_q;
  logic [CW-1:0]    vl_q;
  logic [CW-1:0]    vl_in;
  logic [CW-1:0]    cnt_inc;
  logic             accept;
  logic             we;
  logic             overrun_set;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [DATA_W-1:0] rd_nxt;

  logic [DATA_W-1:0] mem [0:NUM_VREGS*MAX_VL-1];

  // Full-width compare so lengths above 2^CW are still clamped rather than truncated.
  assign vl_in   = (VLR > 32'(MAX_VL)) ? CW'(MAX_VL) : VLR[CW-1:0];
  assign cnt_inc = elem_count + CW'(1);
  assign waddr   = {vsel_q, elem_count[IW-1:0]};
  assign raddr   = {rd_sel, rd_idx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    we          = 1'b0;
    overrun_set = 1'b0;
    busy        = 1'b0;
    wb_done     = 1'b0;
    case (state_q)
      IDLE: begin
        overrun_set = in_valid;
        if (wb_enable) begin
          accept  = 1'b1;
          state_d = (vl_in == '0) ? DONE : ARMED;
        end
      end
      ARMED, FILL: begin
        busy = 1'b1;
        if (in_valid) begin
          we      = 1'b1;
          state_d = (in_last || cnt_inc == vl_q) ? DONE : FILL;
        end
      end
      DONE: begin
        wb_done     = 1'b1;
        overrun_set = in_valid;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsel_q     <= '0;
      vl_q       <= '0;
      elem_count <= '0;
      overrun    <= 1'b0;
    end else if (accept) begin
      vsel_q     <= vreg_sel;
      vl_q       <= vl_in;
      elem_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (we && elem_count != CW'(MAX_VL)) elem_count <= cnt_inc;
      if (overrun_set)                     overrun    <= 1'b1;
    end
  end

  // Register-file storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= in_data;
  end

  always_comb begin
    rd_nxt = mem[raddr];
`ifdef VLW_WRITE_BYPASS_EN
    if (we && waddr == raddr) rd_nxt = in_data;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_nxt;
  end

endmodule
